// File: rtl/dff_arst_reg.sv
// dff_arst_reg: STAGES-deep WIDTH-bit register chain, async active-low reset to RESET_VALUE; ports clk, reset (0=reset), d in, q out
module dff_arst_reg #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 STAGES      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (WIDTH < 1 || STAGES < 1) begin : g_bad_params
    $fatal(1, "dff_arst_reg: WIDTH and STAGES must both be >= 1");
  end
  logic [WIDTH-1:0] stage [STAGES];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= RESET_VALUE;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end
  assign q = stage[STAGES-1];
endmodule

// File: tb/tb_dff_arst_reg.sv
// tb_dff_arst_reg: directed checks of a 1-stage default register and a 3-stage 8'hFF-reset register
module tb_dff_arst_reg;
  logic       clk = 1'b0;
  logic       r0 = 1'b0, r1 = 1'b0;
  logic [7:0] d0 = 8'hAA, d1 = 8'h00;
  logic [7:0] q0, q1;
  int         checks = 0;
  int         failures = 0;
  dff_arst_reg u0 (.clk(clk), .reset(r0), .d(d0), .q(q0));
  dff_arst_reg #(.WIDTH(8), .RESET_VALUE(8'hFF), .STAGES(3)) u1 (.clk(clk), .reset(r1), .d(d1), .q(q1));
  always #10 clk = ~clk;
  task automatic ck(input string name, input bit ok, input logic [7:0] act);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: q=%h at t=%0t", name, act, $time);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) begin
      @(negedge clk);
      ck("por_hold", q0 === 8'h00, q0);
    end
    ck("u1_reset_ff", q1 === 8'hFF, q1);
    r0 = 1'b1;
    #1;
    ck("release_hold", q0 === 8'h00, q0);
    @(posedge clk); #1;
    ck("release_capture", q0 === 8'hAA, q0);
    #4 d0 = 8'h55;
    #1;
    ck("d_change_hold", q0 === 8'hAA, q0);
    @(posedge clk); #1;
    ck("d_change_capture", q0 === 8'h55, q0);
    d0 = 8'hAA;
    @(posedge clk); #1;
    ck("recapture_aa", q0 === 8'hAA, q0);
    #3 r0 = 1'b0;
    #1;
    ck("async_clear", q0 === 8'h00, q0);
    @(posedge clk); #1;
    ck("reset_held_edge", q0 === 8'h00, q0);
    d0 = 8'h3C;
    r0 = 1'b1;
    @(posedge clk); #1;
    ck("track_3c", q0 === 8'h3C, q0);
    #2 r0 = 1'b0;
    #1;
    ck("pulse_clear", q0 === 8'h00, q0);
    #5 r0 = 1'b1;
    d0 = 8'hC3;
    #1;
    ck("pulse_release_hold", q0 === 8'h00, q0);
    @(posedge clk); #1;
    ck("pulse_resume", q0 === 8'hC3, q0);
    @(posedge clk);
    r0 = 1'b0;
    d0 = 8'h99;
    #1;
    ck("reset_at_edge", q0 === 8'h00, q0);
    @(negedge clk);
    d1 = 8'h12;
    r1 = 1'b1;
    #1;
    ck("u1_release_hold", q1 === 8'hFF, q1);
    @(posedge clk); #1;
    d1 = 8'h00;
    ck("u1_lat_edge1", q1 === 8'hFF, q1);
    @(posedge clk); #1;
    ck("u1_lat_edge2", q1 === 8'hFF, q1);
    @(posedge clk); #1;
    ck("u1_lat_edge3", q1 === 8'h12, q1);
    @(posedge clk); #1;
    ck("u1_lat_edge4", q1 === 8'h00, q1);
    d1 = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    r1 = 1'b0;
    #1;
    ck("u1_midpipe_clear", q1 === 8'hFF, q1);
    #3 r1 = 1'b1;
    d1 = 8'h00;
    @(posedge clk); #1;
    ck("u1_flush_edge1", q1 === 8'hFF, q1);
    @(posedge clk); #1;
    ck("u1_flush_edge2", q1 === 8'hFF, q1);
    @(posedge clk); #1;
    ck("u1_flush_edge3", q1 === 8'h00, q1);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
